// File: rtl/prog_loader_pkg.sv
// Purpose: shared types and constants for the boot-time program loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_I = 3'd1,
        ST_LOAD_D = 3'd2,
        ST_RUN    = 3'd3,
        ST_ERR    = 3'd4
    } loader_state_t;

    // Byte distance between consecutive words in each memory.
    localparam int IMEM_STRIDE = 4;
    localparam int DMEM_STRIDE = 8;

endpackage

// File: rtl/ext_write_port.sv
// Purpose: registered address/data/strobe stage driving one SRAM external write port.
// Latency: capture at edge n gives wen high for exactly cycle n+1.
// Backpressure: none; every capture produces one strobe.
// Ports: capture/idx/din in; addr (BASE + idx*STRIDE, mod 2^64), wen, wdata out.
module ext_write_port #(
    parameter int          DW     = 32,
    parameter int          STRIDE = 4,
    parameter logic [63:0] BASE   = 64'd0
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          capture,
    input  logic [15:0]   idx,
    input  logic [DW-1:0] din,
    output logic [63:0]   addr,
    output logic          wen,
    output logic [DW-1:0] wdata
);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            addr  <= 64'd0;
            wen   <= 1'b0;
            wdata <= '0;
        end else begin
            wen <= capture;
            if (capture) begin
                // 64-bit unsigned arithmetic, wraps naturally.
                addr  <= BASE + ({48'd0, idx} * 64'(STRIDE));
                wdata <= din;
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Purpose: streams words into instruction then data memory, then enables the CPU until halt.
// Latency: handshake at edge n -> write strobe in cycle n+1; cpu_enable one cycle after RUN entry.
// Backpressure: s_ready = busy (state-decoded only); s_valid low stalls everything.
// Ports: start/imem_words/dmem_words/halt control; s_valid/s_data/s_ready stream;
//        *_ext imem write port, *_ext_2 dmem write port; cpu_enable, busy, error status.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int          IMEM_DEPTH = 512,
    parameter int          DMEM_DEPTH = 1024,
    parameter logic [63:0] IMEM_BASE  = 64'd0,
    parameter logic [63:0] DMEM_BASE  = 64'd0
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic [15:0] imem_words,
    input  logic [15:0] dmem_words,
    input  logic        halt,
    input  logic        s_valid,
    input  logic [63:0] s_data,
    output logic        s_ready,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    output logic        cpu_enable,
    output logic        busy,
    output logic        error
);

    loader_state_t state, state_nxt;
    logic [15:0]   k;
    logic [15:0]   imem_n;
    logic [15:0]   dmem_n;
    logic          hs;
    logic          hs_i;
    logic          hs_d;
    logic          last_word;
    logic          too_big;

    assign busy      = (state == ST_LOAD_I) || (state == ST_LOAD_D);
    assign error     = (state == ST_ERR);
    assign s_ready   = busy;
    assign ren_ext   = 1'b0;
    assign ren_ext_2 = 1'b0;

    assign hs   = s_valid & s_ready;
    assign hs_i = hs & (state == ST_LOAD_I);
    assign hs_d = hs & (state == ST_LOAD_D);

    // Counts are nonzero in their load phase, so the -1 never underflows there.
    assign last_word = (state == ST_LOAD_I) ? (k == imem_n - 16'd1)
                                            : (k == dmem_n - 16'd1);

    assign too_big = ({16'd0, imem_words} > 32'(IMEM_DEPTH)) ||
                     ({16'd0, dmem_words} > 32'(DMEM_DEPTH));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (too_big)                 state_nxt = ST_ERR;
                    else if (imem_words != 16'd0) state_nxt = ST_LOAD_I;
                    else if (dmem_words != 16'd0) state_nxt = ST_LOAD_D;
                    else                         state_nxt = ST_RUN;
                end
            end
            ST_LOAD_I: begin
                if (hs && last_word)
                    state_nxt = (dmem_n != 16'd0) ? ST_LOAD_D : ST_RUN;
            end
            ST_LOAD_D: begin
                if (hs && last_word) state_nxt = ST_RUN;
            end
            ST_RUN, ST_ERR: begin
                if (halt) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= ST_IDLE;
            k          <= 16'd0;
            imem_n     <= 16'd0;
            dmem_n     <= 16'd0;
            cpu_enable <= 1'b0;
        end else begin
            state      <= state_nxt;
            // Registered from the current state so the final write commits before any fetch.
            cpu_enable <= (state == ST_RUN);
            if (state == ST_IDLE && start) begin
                imem_n <= imem_words;
                dmem_n <= dmem_words;
                k      <= 16'd0;
            end else if (hs) begin
                k <= last_word ? 16'd0 : k + 16'd1;
            end
        end
    end

    ext_write_port #(
        .DW(32), .STRIDE(IMEM_STRIDE), .BASE(IMEM_BASE)
    ) u_imem_port (
        .clk(clk), .arst_n(arst_n), .capture(hs_i), .idx(k), .din(s_data[31:0]),
        .addr(addr_ext), .wen(wen_ext), .wdata(wdata_ext)
    );

    ext_write_port #(
        .DW(64), .STRIDE(DMEM_STRIDE), .BASE(DMEM_BASE)
    ) u_dmem_port (
        .clk(clk), .arst_n(arst_n), .capture(hs_d), .idx(k), .din(s_data),
        .addr(addr_ext_2), .wen(wen_ext_2), .wdata(wdata_ext_2)
    );

endmodule

// File: tb/tb_prog_loader.sv
// Purpose: scoreboard bench for prog_loader; expected writes queued by stimulus, popped by a monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_prog_loader;

    logic        clk;
    logic        arst_n;
    logic        start;
    logic [15:0] imem_words;
    logic [15:0] dmem_words;
    logic        halt;
    logic        s_valid;
    logic [63:0] s_data;
    logic        s_ready;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic        cpu_enable;
    logic        busy;
    logic        error;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t iq[$];
    wr_t dq[$];
    int  checks = 0;
    int  errors = 0;

    prog_loader dut (
        .clk(clk), .arst_n(arst_n), .start(start),
        .imem_words(imem_words), .dmem_words(dmem_words), .halt(halt),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2),
        .cpu_enable(cpu_enable), .busy(busy), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_i(input logic [63:0] a, input logic [63:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        iq.push_back(w);
    endtask

    task automatic push_d(input logic [63:0] a, input logic [63:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        dq.push_back(w);
    endtask

    // Monitor: every strobe seen must match the head of its queue.
    always @(negedge clk) begin
        if (arst_n) begin
            if (wen_ext && wen_ext_2) chk("both_wen", 64'd1, 64'd0);
            if (ren_ext || ren_ext_2) chk("ren_tied", 64'd1, 64'd0);
            if (wen_ext) begin
                if (iq.size() == 0) begin
                    chk("unexpected_wen_ext", addr_ext, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    wr_t w;
                    w = iq.pop_front();
                    chk("addr_ext", addr_ext, w.addr);
                    chk("wdata_ext", {32'd0, wdata_ext}, w.data);
                end
            end
            if (wen_ext_2) begin
                if (dq.size() == 0) begin
                    chk("unexpected_wen_ext_2", addr_ext_2, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    wr_t w;
                    w = dq.pop_front();
                    chk("addr_ext_2", addr_ext_2, w.addr);
                    chk("wdata_ext_2", wdata_ext_2, w.data);
                end
            end
        end
    end

    logic [63:0] words [5];
    logic        vpat  [7];

    initial begin
        arst_n = 1'b0; start = 1'b0; imem_words = 16'd0; dmem_words = 16'd0;
        halt = 1'b0; s_valid = 1'b0; s_data = 64'd0;
        #12;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
        chk("rst_cpu_enable", {63'd0, cpu_enable}, 64'd0);
        chk("rst_error", {63'd0, error}, 64'd0);
        chk("rst_wen", {62'd0, wen_ext, wen_ext_2}, 64'd0);
        chk("rst_addr", addr_ext | addr_ext_2, 64'd0);
        arst_n = 1'b1;
        tick();

        // --- 3 instruction words + 2 data words, continuous valid ---
        words[0] = 64'hDEAD_BEEF_1111_0000;
        words[1] = 64'h0000_0000_2222_0001;
        words[2] = 64'hFFFF_FFFF_3333_0002;
        words[3] = 64'h4444_4444_4444_0003;
        words[4] = 64'h5555_5555_5555_0004;
        push_i(64'd0, 64'h1111_0000);
        push_i(64'd4, 64'h2222_0001);
        push_i(64'd8, 64'h3333_0002);
        push_d(64'd0, words[3]);
        push_d(64'd8, words[4]);
        start = 1'b1; imem_words = 16'd3; dmem_words = 16'd2;
        tick();
        start = 1'b0;
        chk("t1_busy", {63'd0, busy}, 64'd1);
        chk("t1_s_ready", {63'd0, s_ready}, 64'd1);
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data = words[i];
            tick();
        end
        s_valid = 1'b0;
        chk("t1_cpu_en_at_run_entry", {63'd0, cpu_enable}, 64'd0);
        chk("t1_run_s_ready", {63'd0, s_ready}, 64'd0);
        tick();
        chk("t1_cpu_en_rise", {63'd0, cpu_enable}, 64'd1);
        chk("t1_run_busy", {63'd0, busy}, 64'd0);

        // start in RUN is ignored
        start = 1'b1; imem_words = 16'd2; dmem_words = 16'd0;
        tick();
        start = 1'b0;
        chk("t1_start_ignored_busy", {63'd0, busy}, 64'd0);
        chk("t1_start_ignored_en", {63'd0, cpu_enable}, 64'd1);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("t1_halt_en_m", {63'd0, cpu_enable}, 64'd1);
        tick();
        chk("t1_halt_en_m1", {63'd0, cpu_enable}, 64'd0);
        chk("t1_queues_empty", 64'(iq.size() + dq.size()), 64'd0);

        // --- zero-length load ---
        start = 1'b1; imem_words = 16'd0; dmem_words = 16'd0;
        tick();
        start = 1'b0;
        chk("t2_s_ready", {63'd0, s_ready}, 64'd0);
        chk("t2_cpu_en_early", {63'd0, cpu_enable}, 64'd0);
        tick();
        chk("t2_s_ready2", {63'd0, s_ready}, 64'd0);
        chk("t2_cpu_en", {63'd0, cpu_enable}, 64'd1);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        tick();
        chk("t2_cpu_en_off", {63'd0, cpu_enable}, 64'd0);

        // --- oversize imem count -> ERR ---
        start = 1'b1; imem_words = 16'd513; dmem_words = 16'd0;
        tick();
        start = 1'b0;
        s_valid = 1'b1; s_data = 64'h1234;
        chk("t3_error", {63'd0, error}, 64'd1);
        chk("t3_s_ready", {63'd0, s_ready}, 64'd0);
        tick();
        tick();
        chk("t3_error_held", {63'd0, error}, 64'd1);
        chk("t3_no_cpu_en", {63'd0, cpu_enable}, 64'd0);
        s_valid = 1'b0;
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("t3_error_clear", {63'd0, error}, 64'd0);

        // --- imem = 4 with stalls ---
        vpat[0] = 1'b1; vpat[1] = 1'b0; vpat[2] = 1'b0; vpat[3] = 1'b1;
        vpat[4] = 1'b1; vpat[5] = 1'b0; vpat[6] = 1'b1;
        push_i(64'd0,  64'hA000_0000);
        push_i(64'd4,  64'hA000_0001);
        push_i(64'd8,  64'hA000_0002);
        push_i(64'd12, 64'hA000_0003);
        start = 1'b1; imem_words = 16'd4; dmem_words = 16'd0;
        tick();
        start = 1'b0;
        begin
            int n;
            n = 0;
            for (int i = 0; i < 7; i++) begin
                s_valid = vpat[i];
                s_data  = vpat[i] ? (64'hA000_0000 + 64'(n)) : 64'hBAD0_BAD0_BAD0_BAD0;
                if (vpat[i]) n++;
                tick();
                chk("t4_strobe_follows_valid", {63'd0, wen_ext}, {63'd0, vpat[i]});
            end
        end
        s_valid = 1'b0;
        tick();
        chk("t4_cpu_en", {63'd0, cpu_enable}, 64'd1);
        chk("t4_queue_empty", 64'(iq.size()), 64'd0);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        tick();

        // --- reset mid-load after 2 of 5 handshakes ---
        push_i(64'd0, 64'h0000_7000);
        start = 1'b1; imem_words = 16'd5; dmem_words = 16'd0;
        tick();
        start = 1'b0;
        s_valid = 1'b1; s_data = 64'h7000;
        tick();
        s_data = 64'h7001;
        tick();
        s_valid = 1'b0;
        chk("t5_wen_before_rst", {63'd0, wen_ext}, 64'd1);
        #1;
        arst_n = 1'b0;
        #1;
        chk("t5_rst_busy", {63'd0, busy}, 64'd0);
        chk("t5_rst_s_ready", {63'd0, s_ready}, 64'd0);
        chk("t5_rst_wen", {63'd0, wen_ext}, 64'd0);
        chk("t5_rst_cpu_en", {63'd0, cpu_enable}, 64'd0);
        tick();
        tick();
        chk("t5_rst_busy_held", {63'd0, busy}, 64'd0);
        chk("t5_queue_after_rst", 64'(iq.size()), 64'd0);
        arst_n = 1'b1;
        tick();
        push_i(64'd0, 64'h0000_7777);
        start = 1'b1; imem_words = 16'd1; dmem_words = 16'd0;
        tick();
        start = 1'b0;
        s_valid = 1'b1; s_data = 64'h7777;
        tick();
        s_valid = 1'b0;
        tick();
        chk("t5_restart_cpu_en", {63'd0, cpu_enable}, 64'd1);
        chk("t5_final_queues", 64'(iq.size() + dq.size()), 64'd0);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
